shifter_arbiter: RTL

- Shares one 8-bit bidirectional logical barrel shifter between two requesters.
- Each requester presents data, shift amount and direction on a valid/ready handshake; the block grants one request per transaction (round-robin or fixed priority) and drives the shared shifter.
- The result is registered and held with its requester ID until the consumer accepts it.
- Sits between two issuing units and a single result consumer in the lab datapath.

---
 rtl/shifter_arbiter_if.sv | 33 +++
 rtl/shifter_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/shifter_arbiter_if.sv
// Handshake bundle between two shift requesters, the shared shifter and its result consumer.
// master = requester/consumer side, slave = the arbiter.
interface shifter_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_shamt;
  logic       req0_dir;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_shamt;
  logic       req1_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_id;
  logic       busy;

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_dir,
    output req1_valid, req1_data, req1_shamt, req1_dir,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_dir,
    input  req1_valid, req1_data, req1_shamt, req1_dir,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Two requesters share one 8-bit logical barrel shifter; one result is held until the consumer takes it.
//   state | meaning
//   IDLE  | result register empty, grant one pending request
//   HOLD  | result held with requester id until out_ready
module shifter_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  shifter_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e     state_q;
  logic       ptr_q;
  logic       out_valid_q;
  logic       out_id_q;
  logic [7:0] out_data_q;

  logic       grant_id;
  logic       ready0;
  logic       ready1;
  logic       accept;
  logic [7:0] sh_data;
  logic [2:0] sh_amt;
  logic       sh_dir;
  logic [7:0] shift_d;

  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = RR_EN ? ptr_q : 1'b0;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Readys are gated by rst_n so nothing is accepted while reset is held.
  assign ready0 = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id;
  assign ready1 = rst_n && (state_q == IDLE) && bus.req1_valid && grant_id;
  assign accept = ready0 || ready1;

  assign sh_data = grant_id ? bus.req1_data  : bus.req0_data;
  assign sh_amt  = grant_id ? bus.req1_shamt : bus.req0_shamt;
  assign sh_dir  = grant_id ? bus.req1_dir   : bus.req0_dir;
  assign shift_d = sh_dir ? (sh_data << sh_amt) : (sh_data >> sh_amt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            out_data_q  <= shift_d;
            out_id_q    <= grant_id;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
            if (RR_EN) ptr_q <= ~grant_id;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = out_id_q;
  assign bus.busy       = (state_q == HOLD);

endmodule
